// File: rtl/move_selector.sv
// move_selector: keeps the best evaluator result of a move batch, with drain window and beta cutoff
module move_selector #(
  parameter int PIPE_DEPTH = 1,
  parameter int COUNT_W    = 8,
  parameter int MOVE_W     = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic signed [15:0]  beta_in,
  input  logic                gen_done_in,
  input  logic                abort_in,
  input  logic                valid_in,
  input  logic [MOVE_W-1:0]   move_in,
  input  logic signed [15:0]  eval_in,
  output logic                busy_out,
  output logic                done_out,
  output logic [MOVE_W-1:0]   best_move_out,
  output logic signed [15:0]  best_eval_out,
  output logic [COUNT_W-1:0]  num_legal_out,
  output logic                no_legal_out,
  output logic                cutoff_out
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  logic [1:0]         r_state;
  logic [1:0]         w_nxt;
  logic [3:0]         r_drain;
  logic signed [15:0] r_beta;
  logic [MOVE_W-1:0]  r_best_move;
  logic signed [15:0] r_best_eval;
  logic [COUNT_W-1:0] r_cnt;
  logic               r_cut;
  logic               r_nol;
  logic               r_done;
  logic               w_run;
  logic               w_start;
  logic               w_acc;
  logic               w_cut;
  logic               w_fin;
  logic [COUNT_W-1:0] w_cnt_nxt;
  // qualify the inputs: abort beats everything, results count only while a batch runs
  always_comb begin
    w_run     = (r_state == COLLECT) || (r_state == DRAIN);
    w_start   = start_in && !abort_in && !w_run;
    w_acc     = valid_in && !abort_in && w_run;
    w_cut     = w_acc && (eval_in >= r_beta);
    w_cnt_nxt = (w_acc && !(&r_cnt)) ? r_cnt + COUNT_W'(1) : r_cnt;
    w_fin     = (w_nxt == DONE) && (r_state != DONE);
  end
  // state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_nxt;
  end
  // next state: a cutoff ends the batch even when gen_done arrives alongside it
  always_comb begin
    w_nxt = abort_in                                  ? IDLE    :
            w_start                                   ? COLLECT :
            w_cut                                     ? DONE    :
            (r_state == COLLECT && gen_done_in)       ? DRAIN   :
            (r_state == DRAIN && r_drain <= 4'd1)     ? DONE    : r_state;
  end
  // outputs
  always_comb begin
    busy_out      = w_run;
    done_out      = r_done;
    best_move_out = r_best_move;
    best_eval_out = r_best_eval;
    num_legal_out = r_cnt;
    no_legal_out  = r_nol;
    cutoff_out    = r_cut;
  end
  // drain window counts down the results still in flight; done pulses on DONE entry
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_drain <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_drain <= (w_nxt == DRAIN) ? ((r_state == DRAIN) ? r_drain - 4'd1 : 4'(PIPE_DEPTH)) : 4'd0;
      r_done  <= w_fin;
    end
  end
  // batch bookkeeping: clear on start, fold accepted results, ties keep the earlier move
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_beta      <= 16'sh7fff;
      r_best_move <= '0;
      r_best_eval <= 16'sh8000;
      r_cnt       <= '0;
      r_cut       <= 1'b0;
      r_nol       <= 1'b0;
    end else if (w_start) begin
      r_beta      <= beta_in;
      r_best_move <= '0;
      r_best_eval <= 16'sh8000;
      r_cnt       <= '0;
      r_cut       <= 1'b0;
      r_nol       <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_acc && eval_in > r_best_eval) begin
        r_best_move <= move_in;
        r_best_eval <= eval_in;
      end
      if (w_cut) r_cut <= 1'b1;
      if (w_fin) r_nol <= ~|w_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_move_selector.sv
// tb_move_selector: table, directed and randomized checks of move_selector against a batch model
module tb_move_selector;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, gd, abort, valid;
  logic signed [15:0] beta, ev;
  logic [15:0] mv;
  wire [2:0] busy, done, nol, cut;
  wire [2:0][15:0] bm, be;
  wire [2:0][7:0] cnt;
  wire [1:0] c2;
  assign cnt[2] = {6'd0, c2};
  int checks = 0;
  int errors = 0;
  bit mchk = 0;

  move_selector #(.PIPE_DEPTH(1), .COUNT_W(8)) u1 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .beta_in(beta), .gen_done_in(gd),
    .abort_in(abort), .valid_in(valid), .move_in(mv), .eval_in(ev), .busy_out(busy[0]),
    .done_out(done[0]), .best_move_out(bm[0]), .best_eval_out(be[0]), .num_legal_out(cnt[0]),
    .no_legal_out(nol[0]), .cutoff_out(cut[0]));
  move_selector #(.PIPE_DEPTH(3), .COUNT_W(8)) u3 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .beta_in(beta), .gen_done_in(gd),
    .abort_in(abort), .valid_in(valid), .move_in(mv), .eval_in(ev), .busy_out(busy[1]),
    .done_out(done[1]), .best_move_out(bm[1]), .best_eval_out(be[1]), .num_legal_out(cnt[1]),
    .no_legal_out(nol[1]), .cutoff_out(cut[1]));
  move_selector #(.PIPE_DEPTH(1), .COUNT_W(2)) u2c (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .beta_in(beta), .gen_done_in(gd),
    .abort_in(abort), .valid_in(valid), .move_in(mv), .eval_in(ev), .busy_out(busy[2]),
    .done_out(done[2]), .best_move_out(bm[2]), .best_eval_out(be[2]), .num_legal_out(c2),
    .no_legal_out(nol[2]), .cutoff_out(cut[2]));

  function automatic int pd(int k);
    return (k == 1) ? 3 : 1;
  endfunction
  function automatic int cmax(int k);
    return (k == 2) ? 3 : 255;
  endfunction

  task automatic chk(string nm, int k, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s act=%0d exp=%0d at %0t", k, nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(int k, bit d, bit b, int e, int m, int c, bit ct, bit nl);
    chk("done", k, {31'd0, done[k]}, {31'd0, d});
    chk("busy", k, {31'd0, busy[k]}, {31'd0, b});
    chk("best_eval", k, $signed(be[k]), e);
    chk("best_move", k, {16'd0, bm[k]}, m);
    chk("num_legal", k, {24'd0, cnt[k]}, c);
    chk("cutoff", k, {31'd0, cut[k]}, {31'd0, ct});
    chk("no_legal", k, {31'd0, nol[k]}, {31'd0, nl});
  endtask

  // batch model: a batch is active until a cutoff or until the drain window after gen_done runs out
  bit m_act[3], m_cut[3], m_nol[3], m_done[3];
  int m_cnt[3], m_left[3];
  logic signed [15:0] m_be[3], m_beta[3];
  logic [15:0] m_bm[3];

  task automatic mreset(int k);
    m_act[k] = 0; m_cut[k] = 0; m_nol[k] = 0; m_done[k] = 0;
    m_cnt[k] = 0; m_left[k] = 0; m_be[k] = -16'sd32768; m_bm[k] = 0; m_beta[k] = 0;
  endtask

  task automatic mstep(int k);
    bit fin;
    fin = 0;
    m_done[k] = 0;
    if (abort) m_act[k] = 0;
    else if (!m_act[k]) begin
      if (start) begin
        m_act[k] = 1; m_left[k] = 0; m_beta[k] = beta; m_cnt[k] = 0;
        m_be[k] = -16'sd32768; m_bm[k] = 0; m_cut[k] = 0; m_nol[k] = 0;
      end
    end else begin
      if (valid) begin
        if (m_cnt[k] < cmax(k)) m_cnt[k]++;
        if (ev > m_be[k]) begin m_be[k] = ev; m_bm[k] = mv; end
        if (ev >= m_beta[k]) begin m_cut[k] = 1; fin = 1; end
      end
      if (!fin) begin
        if (m_left[k] > 0) begin m_left[k]--; fin = (m_left[k] == 0); end
        else if (gd) m_left[k] = pd(k);
      end
      if (fin) begin m_act[k] = 0; m_done[k] = 1; m_nol[k] = (m_cnt[k] == 0); end
    end
  endtask

  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 3; k++)
      if (!rst_n) mreset(k);
      else mstep(k);

  always @(negedge clk)
    if (mchk)
      for (int k = 0; k < 3; k++)
        chk_all(k, m_done[k], m_act[k], m_be[k], m_bm[k], m_cnt[k], m_cut[k], m_nol[k]);

  typedef struct {
    bit st; int bt; bit g; bit ab; bit v; int m; int e;
    bit x_done; bit x_busy; int x_be; int x_bm; int x_cnt; bit x_cut; bit x_nol;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit st, int bt, bit g, bit ab, bit v, int m, int e,
                              bit d, bit b, int xe, int xm, int c, bit ct, bit nl);
    vec_t r;
    r.st = st; r.bt = bt; r.g = g; r.ab = ab; r.v = v; r.m = m; r.e = e;
    r.x_done = d; r.x_busy = b; r.x_be = xe; r.x_bm = xm; r.x_cnt = c; r.x_cut = ct; r.x_nol = nl;
    return r;
  endfunction

  task automatic idle_in();
    start = 0; gd = 0; abort = 0; valid = 0; beta = 0; mv = 0; ev = 0;
  endtask

  task automatic cyc(bit st, int bt, bit g, bit ab, bit v, int m, int e);
    start = st; beta = 16'(bt); gd = g; abort = ab; valid = v; mv = 16'(m); ev = 16'(e);
    @(posedge clk);
    #1;
    idle_in();
  endtask

  initial begin
    // main batch: tie at 40 keeps C, done two cycles after gen_done
    tbl.push_back(mk(1, 32767, 0, 0, 0, 0, 0,      0, 1, -32768, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'hA, 10,       0, 1, 10, 'hA, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'hB, -5,       0, 1, 10, 'hA, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'hC, 40,       0, 1, 40, 'hC, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'hD, 40,       0, 1, 40, 'hC, 4, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,          0, 1, 40, 'hC, 4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,          1, 0, 40, 'hC, 4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,          0, 0, 40, 'hC, 4, 0, 0));
    // empty batch
    tbl.push_back(mk(1, 500, 0, 0, 0, 0, 0,        0, 1, -32768, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,          0, 1, -32768, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,          1, 0, -32768, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,          0, 0, -32768, 0, 0, 0, 1));
    // beta cutoff at 120, later 300 ignored
    tbl.push_back(mk(1, 100, 0, 0, 0, 0, 0,        0, 1, -32768, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h51, 50,      0, 1, 50, 'h51, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h52, 120,     1, 0, 120, 'h52, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h53, 300,     0, 0, 120, 'h52, 2, 1, 0));
    // valid with start dropped, start while collecting ignored, abort beats start
    tbl.push_back(mk(1, 32767, 0, 0, 1, 'h99, 99,  0, 1, -32768, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h61, 7,       0, 1, 7, 'h61, 1, 0, 0));
    tbl.push_back(mk(1, -1000, 0, 0, 1, 'h62, 8,   0, 1, 8, 'h62, 2, 0, 0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0,          0, 0, 8, 'h62, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,          0, 0, 8, 'h62, 2, 0, 0));

    idle_in();
    rst_n = 0;
    @(posedge clk);
    #1;
    mchk = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_all(k, 0, 0, -32768, 0, 0, 0, 0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].bt, tbl[i].g, tbl[i].ab, tbl[i].v, tbl[i].m, tbl[i].e);
      chk_all(0, tbl[i].x_done, tbl[i].x_busy, tbl[i].x_be, tbl[i].x_bm,
              tbl[i].x_cnt, tbl[i].x_cut, tbl[i].x_nol);
    end

    // three-deep drain: a result on the last drain cycle still counts
    cyc(1, 32767, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drain3_busy", 1, {31'd0, busy[1]}, 1);
    chk("drain3_done", 1, {31'd0, done[1]}, 0);
    cyc(0, 0, 0, 0, 1, 'h70, 70);
    chk_all(1, 1, 0, 70, 'h70, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drain3_pulse", 1, {31'd0, done[1]}, 0);

    // abort mid-collect keeps last outputs, no done
    cyc(1, 32767, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 'h25, 25);
    cyc(0, 0, 0, 1, 1, 'h99, 99);
    chk_all(0, 0, 0, 25, 'h25, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("abort_done", 0, {31'd0, done[0]}, 0);

    // reset mid-drain
    cyc(1, 32767, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 'h33, 33);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_busy", 1, {31'd0, busy[1]}, 1);
    rst_n = 0;
    #1;
    chk_all(1, 0, 0, -32768, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all(1, 0, 0, -32768, 0, 0, 0, 0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_busy", 1, {31'd0, busy[1]}, 0);
    chk("post_rst_done", 1, {31'd0, done[1]}, 0);

    // two-bit counter saturates at 3
    cyc(1, 32767, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, 1, i, i * 10);
    chk("sat_cnt", 2, {24'd0, cnt[2]}, 3);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_all(2, 1, 0, 50, 5, 3, 0, 0);

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(399) != 0);
      start = ($urandom_range(15) == 0);
      gd = ($urandom_range(11) == 0);
      abort = ($urandom_range(63) == 0);
      valid = $urandom_range(1) == 1;
      beta = ($urandom_range(3) == 0) ? 16'sd32767 : 16'(int'($urandom_range(400)) - 100);
      ev = 16'(int'($urandom_range(500)) - 250);
      mv = 16'($urandom);
      @(posedge clk);
      #1;
    end
    rst_n = 1;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    mchk = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/move_selector.md
MOVE_SELECTOR -- requirements
Module: move_selector

Interface
REQ-001 The block SHALL have parameter PIPE_DEPTH, default 1: evaluator pipeline latency in cycles, range 1-15.
REQ-002 The block SHALL have parameter COUNT_W, default 8: width of the legal-move counter.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; all state is on the rising edge.
REQ-004 The block SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_in, input, 1 bit: one-cycle pulse that opens a new batch; honoured only in IDLE or DONE.
REQ-006 The block SHALL have port beta_in, input, eval_t (signed 16): cutoff bound, sampled on start_in.
REQ-007 The block SHALL have port gen_done_in, input, 1 bit: pulse meaning the move generator has issued its last move into the evaluator.
REQ-008 The block SHALL have port abort_in, input, 1 bit: discards the batch.
REQ-009 The block SHALL have port valid_in, input, 1 bit: evaluator result valid; the evaluator drives it low for illegal moves.
REQ-010 The block SHALL have port move_in, input, move_t: move paired with eval_in.
REQ-011 The block SHALL have port eval_in, input, eval_t (signed 16): side-to-move score.
REQ-012 The block SHALL have port busy_out, output, 1 bit: high in COLLECT or DRAIN.
REQ-013 The block SHALL have port done_out, output, 1 bit: one-cycle pulse when the result is final.
REQ-014 The block SHALL have port best_move_out, output, move_t: best move of the batch.
REQ-015 The block SHALL have port best_eval_out, output, eval_t: score of best_move_out.
REQ-016 The block SHALL have port num_legal_out, output, COUNT_W bits: count of valid results accepted.
REQ-017 The block SHALL have port no_legal_out, output, 1 bit: batch finished with zero valid results.
REQ-018 The block SHALL have port cutoff_out, output, 1 bit: batch ended early because best_eval reached beta.

Function
REQ-019 The block SHALL use states IDLE, COLLECT, DRAIN and DONE.
REQ-020 On start_in in IDLE or DONE, the block SHALL go to COLLECT, latch beta_in, clear the count, clear cutoff and no_legal, and set best_eval to -32768 and best_move to 0.
REQ-021 start_in in COLLECT or DRAIN SHALL be ignored.
REQ-022 In COLLECT or DRAIN, each cycle with valid_in=1 SHALL increment the count, saturating at 2^COUNT_W-1, and replace best when eval_in > best_eval (signed); ties keep the earlier move.
REQ-023 A valid_in arriving in the same cycle as start_in, or in IDLE or DONE, SHALL be dropped.
REQ-024 gen_done_in in COLLECT SHALL move the block to DRAIN and load the drain counter with PIPE_DEPTH.
REQ-025 In DRAIN, the drain counter SHALL decrement each cycle; results keep being accepted while it is nonzero.
REQ-026 When the drain counter decrements from 1 to 0, the block SHALL go to DONE.
REQ-027 If an accepted eval_in >= latched beta (signed), the block SHALL set cutoff and go to DONE next cycle from COLLECT or DRAIN; results arriving after that SHALL be ignored.
REQ-028 If gen_done_in and a cutoff happen in the same cycle, the cutoff SHALL win and the block SHALL go directly to DONE.
REQ-029 done_out SHALL pulse for exactly the first cycle in DONE; no_legal_out SHALL equal (count==0) from that cycle on.
REQ-030 best_move_out, best_eval_out, num_legal_out, no_legal_out and cutoff_out SHALL be registered and held stable in DONE until the next accepted start_in.
REQ-031 abort_in in any state SHALL force IDLE next cycle with no done_out and SHALL leave the outputs at their last values.
REQ-032 If abort_in and start_in are both high, abort_in SHALL win.
REQ-033 gen_done_in outside COLLECT SHALL be ignored.

Reset
REQ-034 While rst_in=0, the block SHALL be in IDLE with busy_out=0, done_out=0, best_move_out=0, best_eval_out=-32768, num_legal_out=0, no_legal_out=0, cutoff_out=0, and drain counter=0.
REQ-035 Reset asserted mid-batch SHALL discard the batch immediately; the first cycle after release SHALL be IDLE with no done_out.

Verification
REQ-036 The bench SHALL cover: start (beta=32767); valid evals 10, -5, 40, 40 (moves A, B, C, D); gen_done; PIPE_DEPTH=1 -> done_out 2 cycles after gen_done, best=C/40, num_legal=4, cutoff=0, no_legal=0.
REQ-037 The bench SHALL cover: start, then gen_done with no valid_in -> done_out after drain, no_legal_out=1, best_eval=-32768.
REQ-038 The bench SHALL cover: start (beta=100); evals 50 then 120 then 300 -> DONE the cycle after 120, best=120, num_legal=2, cutoff=1, and 300 ignored.
REQ-039 The bench SHALL cover: PIPE_DEPTH=3; gen_done, then valid eval 70 on drain cycle 3 -> accepted, best=70, done_out on the following cycle.
REQ-040 The bench SHALL cover: abort_in mid-COLLECT, and separately rst_in low mid-DRAIN -> no done_out, IDLE; on rst_in low, outputs hold their reset values.
REQ-041 The bench SHALL cover: COUNT_W=2 with 5 valid results -> num_legal_out=3, saturated.
